// File: rtl/riscv_jp_pkg.sv
// Shared jump-predictor types: 2-bit saturating confidence counter, its
// encodings, per-cycle counter operations and saturating helpers.
package riscv_jp_pkg;

  typedef logic [1:0] jp_ctr_t;

  localparam jp_ctr_t JP_CTR_MIN    = 2'd0;
  localparam jp_ctr_t JP_CTR_WEAK_T = 2'd2;
  localparam jp_ctr_t JP_CTR_MAX    = 2'd3;

  typedef enum logic [1:0] {
    CTR_HOLD = 2'd0,
    CTR_LOAD = 2'd1,
    CTR_INC  = 2'd2,
    CTR_DEC  = 2'd3
  } jp_ctr_op_t;

  function automatic jp_ctr_t jp_sat_inc(input jp_ctr_t c);
    return (c == JP_CTR_MAX) ? c : c + 2'd1;
  endfunction

  function automatic jp_ctr_t jp_sat_dec(input jp_ctr_t c);
    return (c == JP_CTR_MIN) ? c : c - 2'd1;
  endfunction

  function automatic logic jp_predicts_taken(input jp_ctr_t c);
    return c >= JP_CTR_WEAK_T;
  endfunction

endpackage

// File: rtl/riscv_btb_sat_counter.sv
// One BTB confidence counter: synchronous clear, load, saturating inc/dec.
module riscv_btb_sat_counter
  import riscv_jp_pkg::*;
(
  input  logic       clk,
  input  logic       clr,
  input  jp_ctr_op_t op,
  input  jp_ctr_t    load_val,
  output jp_ctr_t    ctr
);

  always_ff @(posedge clk) begin
    if (clr) begin
      ctr <= JP_CTR_MIN;
    end else begin
      unique case (op)
        CTR_LOAD: ctr <= load_val;
        CTR_INC:  ctr <= jp_sat_inc(ctr);
        CTR_DEC:  ctr <= jp_sat_dec(ctr);
        default:  ctr <= ctr;
      endcase
    end
  end

endmodule

// File: rtl/riscv_next_strategy_btb.sv
// Direct-mapped BTB next-PC strategy with per-entry 2-bit confidence.
// Optional pinned entry enabled by defining RISCV_BTB_STATIC_ENTRY_EN.
module riscv_next_strategy_btb
  import riscv_jp_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 64,
  parameter int                    ENTRIES     = 16,
  parameter int                    PC_LSB      = 2,
  parameter logic [ADDR_WIDTH-1:0] STATIC_FROM = ADDR_WIDTH'(20),
  parameter logic [ADDR_WIDTH-1:0] STATIC_TO   = ADDR_WIDTH'(44)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  i_stall,
  input  logic                  i_flush,
  input  logic [ADDR_WIDTH-1:0] i_pm_pc,
  output logic                  o_inject,
  output logic [ADDR_WIDTH-1:0] o_inject_addr,
  input  logic                  i_upd_valid,
  input  logic [ADDR_WIDTH-1:0] i_upd_pc,
  input  logic                  i_upd_taken,
  input  logic [ADDR_WIDTH-1:0] i_upd_target
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_WIDTH - PC_LSB - IDX_W;

  logic                  valid_q  [ENTRIES];
  logic [TAG_W-1:0]      tag_q    [ENTRIES];
  logic [ADDR_WIDTH-1:0] target_q [ENTRIES];
  jp_ctr_t               ctr_q    [ENTRIES];
  jp_ctr_op_t            ctr_op   [ENTRIES];

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;
  logic             static_hit;

  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_hit;
  logic             upd_static;
  logic             upd_fire;
  logic             upd_alloc_or_retarget;
  jp_ctr_op_t       upd_op;

  // Lookup path: purely combinational against the registered state.
  assign lk_idx = i_pm_pc[PC_LSB+IDX_W-1:PC_LSB];
  assign lk_tag = i_pm_pc[ADDR_WIDTH-1:PC_LSB+IDX_W];
  assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

`ifdef RISCV_BTB_STATIC_ENTRY_EN
  assign static_hit = (i_pm_pc == STATIC_FROM);
  assign upd_static = (i_upd_pc == STATIC_FROM);
`else
  logic unused_static;
  assign static_hit    = 1'b0;
  assign upd_static    = 1'b0;
  assign unused_static = ^{STATIC_FROM, STATIC_TO};
`endif

  logic unused_low_pc;
  assign unused_low_pc = ^{i_pm_pc[PC_LSB-1:0], i_upd_pc[PC_LSB-1:0]};

  always_comb begin
    o_inject      = 1'b0;
    o_inject_addr = '0;
    if (enable && !reset) begin
      if (static_hit) begin
        o_inject      = 1'b1;
        o_inject_addr = STATIC_TO;
      end else if (lk_hit && jp_predicts_taken(ctr_q[lk_idx])) begin
        o_inject      = 1'b1;
        o_inject_addr = target_q[lk_idx];
      end
    end
  end

  // Update port: i_upd_valid is a single-cycle report with no ready. A report
  // is consumed on the rising edge where it is valid while enabled, not
  // stalled, not flushed and not in reset; under i_stall the producer holds it.
  assign upd_idx  = i_upd_pc[PC_LSB+IDX_W-1:PC_LSB];
  assign upd_tag  = i_upd_pc[ADDR_WIDTH-1:PC_LSB+IDX_W];
  assign upd_hit  = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  assign upd_fire = i_upd_valid && enable && !i_stall && !i_flush && !reset && !upd_static;

  // A taken report either retargets the hit entry or (re)allocates the slot.
  assign upd_alloc_or_retarget = upd_fire && i_upd_taken;

  always_comb begin
    upd_op = CTR_HOLD;
    if (upd_fire) begin
      if (upd_hit) begin
        upd_op = i_upd_taken ? CTR_INC : CTR_DEC;
      end else if (i_upd_taken) begin
        upd_op = CTR_LOAD;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      ctr_op[i] = CTR_HOLD;
      if (upd_idx == IDX_W'(i)) begin
        ctr_op[i] = upd_op;
      end
    end
  end

  for (genvar g = 0; g < ENTRIES; g++) begin : g_ctr
    riscv_btb_sat_counter u_ctr (
      .clk      (clk),
      .clr      (reset),
      .op       (ctr_op[g]),
      .load_val (JP_CTR_WEAK_T),
      .ctr      (ctr_q[g])
    );
  end

  // Flush clears only the valid bits; the next allocation rewrites the rest.
  always_ff @(posedge clk) begin
    for (int i = 0; i < ENTRIES; i++) begin
      if (reset) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
      end else if (i_flush) begin
        valid_q[i]  <= 1'b0;
      end else if (upd_alloc_or_retarget && (upd_idx == IDX_W'(i))) begin
        valid_q[i]  <= 1'b1;
        tag_q[i]    <= upd_tag;
        target_q[i] <= i_upd_target;
      end
    end
  end

endmodule

// File: tb/tb_riscv_next_strategy_btb.sv
// Bench for riscv_next_strategy_btb: directed vector table, then random
// traffic against a behavioural BTB model (honours RISCV_BTB_STATIC_ENTRY_EN).
module tb_riscv_next_strategy_btb;

  localparam int AW = 64;

  logic          clk = 1'b0;
  logic          reset, enable, i_stall, i_flush;
  logic [AW-1:0] i_pm_pc, i_upd_pc, i_upd_target, o_inject_addr;
  logic          i_upd_valid, i_upd_taken, o_inject;

  int checks = 0;
  int errors = 0;

  logic [AW:0] exp_q[$];

  always #5 clk = ~clk;

  riscv_next_strategy_btb #(
    .ADDR_WIDTH  (AW),
    .ENTRIES     (16),
    .PC_LSB      (2),
    .STATIC_FROM (64'd20),
    .STATIC_TO   (64'd44)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .i_stall       (i_stall),
    .i_flush       (i_flush),
    .i_pm_pc       (i_pm_pc),
    .o_inject      (o_inject),
    .o_inject_addr (o_inject_addr),
    .i_upd_valid   (i_upd_valid),
    .i_upd_pc      (i_upd_pc),
    .i_upd_taken   (i_upd_taken),
    .i_upd_target  (i_upd_target)
  );

  // Behavioural model: 16 slots, slot = (pc/4) mod 16, tag = pc/64.
  bit            m_valid [16];
  logic [AW-1:0] m_tag   [16];
  logic [AW-1:0] m_tgt   [16];
  int            m_ctr   [16];

  function automatic bit is_static_pc(input logic [AW-1:0] pc);
`ifdef RISCV_BTB_STATIC_ENTRY_EN
    return pc == 64'd20;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [AW:0] model_predict();
    int s;
    s = int'((i_pm_pc >> 2) % 64'd16);
    if (!enable || reset) return '0;
    if (is_static_pc(i_pm_pc)) return {1'b1, 64'd44};
    if (m_valid[s] && m_tag[s] == (i_pm_pc >> 6) && m_ctr[s] >= 2) return {1'b1, m_tgt[s]};
    return '0;
  endfunction

  task automatic model_commit();
    int  s;
    bit  hit;
    s = int'((i_upd_pc >> 2) % 64'd16);
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        m_valid[i] = 0; m_tag[i] = '0; m_tgt[i] = '0; m_ctr[i] = 0;
      end
    end else if (i_flush) begin
      for (int i = 0; i < 16; i++) m_valid[i] = 0;
    end else if (i_upd_valid && enable && !i_stall && !is_static_pc(i_upd_pc)) begin
      hit = m_valid[s] && m_tag[s] == (i_upd_pc >> 6);
      if (hit && i_upd_taken) begin
        m_ctr[s] = (m_ctr[s] + 1 > 3) ? 3 : m_ctr[s] + 1;
        m_tgt[s] = i_upd_target;
      end else if (hit) begin
        m_ctr[s] = (m_ctr[s] - 1 < 0) ? 0 : m_ctr[s] - 1;
      end else if (i_upd_taken) begin
        m_valid[s] = 1; m_tag[s] = i_upd_pc >> 6; m_tgt[s] = i_upd_target; m_ctr[s] = 2;
      end
    end
  endtask

  task automatic drive(input logic rst, input logic en, input logic stall, input logic flush,
                       input logic [AW-1:0] pc, input logic uv, input logic [AW-1:0] upc,
                       input logic taken, input logic [AW-1:0] tgt);
    reset = rst; enable = en; i_stall = stall; i_flush = flush; i_pm_pc = pc;
    i_upd_valid = uv; i_upd_pc = upc; i_upd_taken = taken; i_upd_target = tgt;
  endtask

  task automatic check_outputs(input string name);
    logic [AW:0] e;
    e = exp_q.pop_front();
    checks++;
    if (o_inject !== e[AW]) begin
      errors++;
      $display("FAIL %s o_inject: got %0b expected %0b", name, o_inject, e[AW]);
    end
    checks++;
    if (o_inject_addr !== e[AW-1:0]) begin
      errors++;
      $display("FAIL %s o_inject_addr: got %0d expected %0d", name, o_inject_addr, e[AW-1:0]);
    end
  endtask

  // Outputs checked mid-cycle (pre-edge state), then the edge commits the model.
  task automatic run_cycle(input string name);
    #1;
    check_outputs(name);
    @(posedge clk);
    model_commit();
    #2;
  endtask

  typedef struct {
    logic          rst, en, stall, flush;
    logic [AW-1:0] pc;
    logic          uv;
    logic [AW-1:0] upc;
    logic          taken;
    logic [AW-1:0] tgt;
    logic          exp_inj;
    logic [AW-1:0] exp_addr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic en, input logic stall, input logic flush,
                     input logic [AW-1:0] pc, input logic uv, input logic [AW-1:0] upc,
                     input logic taken, input logic [AW-1:0] tgt,
                     input logic exp_inj, input logic [AW-1:0] exp_addr);
    vec_t v;
    v.rst = rst; v.en = en; v.stall = stall; v.flush = flush; v.pc = pc;
    v.uv = uv; v.upc = upc; v.taken = taken; v.tgt = tgt;
    v.exp_inj = exp_inj; v.exp_addr = exp_addr;
    vecs.push_back(v);
  endtask

  function automatic logic [AW-1:0] rand_pc();
    logic [AW-1:0] p;
    p = (64'($urandom_range(0, 2)) << 6) | (64'($urandom_range(0, 15)) << 2);
    if ($urandom_range(0, 7) == 0) p = p | 64'($urandom_range(0, 3));
    if ($urandom_range(0, 5) == 0) p = 64'd20;
    if ($urandom_range(0, 31) == 0) p = {$urandom, $urandom};
    return p;
  endfunction

  initial begin
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0; m_tag[i] = '0; m_tgt[i] = '0; m_ctr[i] = 0;
    end
    drive(1, 1, 0, 0, 64'd20, 0, 64'd0, 0, 64'd0);

`ifdef RISCV_BTB_STATIC_ENTRY_EN
    //   rst en st fl pc      uv upc     tk tgt      inj addr
    add(1, 1, 0, 0, 64'd20, 0, 64'd0,  0, 64'd0,   0, 64'd0);
    add(0, 1, 0, 0, 64'd20, 0, 64'd0,  0, 64'd0,   1, 64'd44);
    add(0, 1, 0, 0, 64'd20, 1, 64'd20, 1, 64'd60,  1, 64'd44);
    add(0, 1, 0, 0, 64'd20, 0, 64'd0,  0, 64'd0,   1, 64'd44);
    add(0, 1, 0, 0, 64'd24, 1, 64'd24, 1, 64'd96,  0, 64'd0);
    add(0, 1, 0, 0, 64'd24, 0, 64'd0,  0, 64'd0,   1, 64'd96);
    add(0, 1, 0, 1, 64'd20, 0, 64'd0,  0, 64'd0,   1, 64'd44);
    add(0, 1, 0, 0, 64'd24, 0, 64'd0,  0, 64'd0,   0, 64'd0);
    add(0, 0, 0, 0, 64'd20, 0, 64'd0,  0, 64'd0,   0, 64'd0);
    add(1, 1, 0, 0, 64'd20, 0, 64'd0,  0, 64'd0,   0, 64'd0);
`else
    //   rst en st fl pc      uv upc     tk tgt      inj addr
    add(1, 1, 0, 0, 64'd20, 1, 64'd20, 1, 64'd44,  0, 64'd0);
    add(0, 1, 0, 0, 64'd20, 0, 64'd0,  0, 64'd0,   0, 64'd0);
    add(0, 1, 0, 0, 64'd20, 1, 64'd20, 1, 64'd44,  0, 64'd0);
    add(0, 1, 0, 0, 64'd20, 0, 64'd0,  0, 64'd0,   1, 64'd44);
    add(0, 1, 0, 0, 64'd20, 1, 64'd20, 0, 64'd0,   1, 64'd44);
    add(0, 1, 0, 0, 64'd20, 0, 64'd0,  0, 64'd0,   0, 64'd0);
    add(0, 1, 0, 0, 64'd20, 1, 64'd20, 1, 64'd44,  0, 64'd0);
    add(0, 1, 0, 0, 64'd20, 1, 64'd20, 1, 64'd44,  1, 64'd44);
    add(0, 1, 0, 0, 64'd20, 1, 64'd20, 1, 64'd44,  1, 64'd44);
    add(0, 1, 0, 0, 64'd20, 1, 64'd20, 0, 64'd0,   1, 64'd44);
    add(0, 1, 0, 0, 64'd20, 0, 64'd0,  0, 64'd0,   1, 64'd44);
    add(0, 1, 0, 0, 64'd84, 1, 64'd84, 1, 64'd100, 0, 64'd0);
    add(0, 1, 0, 0, 64'd20, 0, 64'd0,  0, 64'd0,   0, 64'd0);
    add(0, 1, 0, 0, 64'd84, 0, 64'd0,  0, 64'd0,   1, 64'd100);
    add(0, 0, 0, 0, 64'd84, 1, 64'd84, 0, 64'd0,   0, 64'd0);
    add(0, 1, 0, 0, 64'd84, 0, 64'd0,  0, 64'd0,   1, 64'd100);
    add(0, 1, 1, 0, 64'd84, 1, 64'd84, 0, 64'd0,   1, 64'd100);
    add(0, 1, 0, 0, 64'd84, 0, 64'd0,  0, 64'd0,   1, 64'd100);
    add(0, 1, 0, 1, 64'd84, 1, 64'd20, 1, 64'd44,  1, 64'd100);
    add(0, 1, 0, 0, 64'd84, 0, 64'd0,  0, 64'd0,   0, 64'd0);
    add(0, 1, 0, 0, 64'd20, 0, 64'd0,  0, 64'd0,   0, 64'd0);
    add(0, 1, 0, 0, 64'd40, 1, 64'd40, 1, 64'd200, 0, 64'd0);
    add(0, 1, 0, 0, 64'd40, 0, 64'd0,  0, 64'd0,   1, 64'd200);
    add(0, 1, 0, 0, 64'd40, 1, 64'd40, 1, 64'd300, 1, 64'd200);
    add(0, 1, 0, 0, 64'd40, 0, 64'd0,  0, 64'd0,   1, 64'd300);
    add(1, 1, 0, 0, 64'd40, 1, 64'd40, 1, 64'd200, 0, 64'd0);
    add(0, 1, 0, 0, 64'd40, 0, 64'd0,  0, 64'd0,   0, 64'd0);
    add(0, 1, 0, 0, 64'd43, 1, 64'd41, 1, 64'd500, 0, 64'd0);
    add(0, 1, 0, 0, 64'd42, 0, 64'd0,  0, 64'd0,   1, 64'd500);
`endif

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].stall, vecs[i].flush, vecs[i].pc,
            vecs[i].uv, vecs[i].upc, vecs[i].taken, vecs[i].tgt);
      exp_q.push_back({vecs[i].exp_inj, vecs[i].exp_addr});
      run_cycle($sformatf("vec%0d", i));
    end

    drive(1, 1, 0, 0, 64'd0, 0, 64'd0, 0, 64'd0);
    exp_q.push_back(model_predict());
    run_cycle("rand_reset");

    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 149) == 0,
            $urandom_range(0, 9) != 0,
            $urandom_range(0, 7) == 0,
            $urandom_range(0, 49) == 0,
            rand_pc(),
            $urandom_range(0, 9) < 7,
            rand_pc(),
            $urandom_range(0, 9) < 6,
            {$urandom, $urandom});
      exp_q.push_back(model_predict());
      run_cycle($sformatf("rand%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
